mips_run_ctrl: RTL
==================

# mips_run_ctrl

Synthesizable run-control block that sequences a MIPS core through reset, free-run or single-step execution, and halt. It sits between the board/debug controls and `mips_top`. It drives the core's reset and a clock enable, watches `pc_current` against a configurable set of breakpoints and a cycle budget, and reports why and when the core stopped. It is the hardware successor to bench-side clock/reset/PC-watch sequencing, generalised to N breakpoints, a programmable limit, and a single-step mode.

## Interface
Parameters:
- `PC_W`, 32, width of program counter
- `N_BP`, 2, number of breakpoint comparators (≥1)
- `CYC_W`, 16, width of cycle counter and limit
- `RST_CYCLES`, 1, cycles `core_rst` is held in RESET state (≥1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a run from IDLE or HALT
- `single_step`  in  1  mode select, sampled on accepted `start`
- `step`  in  1  pulse; one enabled core cycle while in PAUSE
- `resume`  in  1  pulse; PAUSE → RUN
- `abort`  in  1  pulse; forces HALT from RESET/RUN/PAUSE
- `cycle_limit`  in  CYC_W  enabled-cycle budget, sampled on accepted `start`; 0 = unlimited
- `bp_addr`  in  N_BP*PC_W  breakpoint addresses, entry i at bits [i*PC_W +: PC_W]
- `bp_en`  in  N_BP  per-breakpoint enable
- `pc_current`  in  PC_W  core PC
- `core_rst`  out  1  reset to core
- `core_en`  out  1  core clock enable
- `state`  out  3  IDLE=0, RESET=1, RUN=2, PAUSE=3, HALT=4
- `cycles`  out  CYC_W  enabled cycles since last `start`
- `halt_cause`  out  2  0 none, 1 breakpoint, 2 limit, 3 abort
- `bp_hit`  out  N_BP  breakpoints matching at halt
- `done`  out  1  one-cycle pulse on entry to HALT

## Operation
- `stop_now` = `abort` | any(`bp_en[i]` & `pc_current`==`bp_addr[i]`) | (`limit`≠0 & `cycles`==`limit`).
- `core_rst` = `rst` | (state==RESET), combinational.
- `core_en` is combinational:
  - RUN: `core_en` = ~`stop_now`.
  - PAUSE: `core_en` = `step` & ~`stop_now`.
  - All other states: 0.
- A breakpoint halts the core before the instruction at the matching PC executes.
- IDLE/HALT + `start` → RESET. The same edge clears `cycles`, `halt_cause` and `bp_hit`, and latches the mode and limit.
- RESET: held for RST_CYCLES cycles, then → RUN (or → PAUSE if the latched mode is single-step).
- RUN:
  - `stop_now` → HALT.
  - Otherwise stay in RUN.
- PAUSE:
  - `abort` → HALT.
  - `step` & `stop_now` → HALT.
  - `resume` → RUN.
  - `step` alone: one enabled cycle, stay in PAUSE.
- HALT: hold until `start`.
- `start` is ignored in RESET/RUN/PAUSE. `step`/`resume` are ignored outside PAUSE.
- Halt cause priority: abort > breakpoint > limit.
- `bp_hit` records every matching enabled comparator, not just the lowest index.
- `cycles` increments on every cycle with `core_en`=1 and saturates at all-ones.
- `resume` and `step` in the same cycle: `step` takes effect (one cycle), then the state goes to RUN.

## Timing
- All outputs are registered except `core_rst` and `core_en`.
- Reset values:
  - `state`=IDLE, `cycles`=0, `halt_cause`=0, `bp_hit`=0, `done`=0, `core_en`=0.
  - `core_rst`=1 while `rst` is high.
- `rst` mid-run: IDLE on the next edge. The latched mode and limit are cleared.
- `start` → `core_rst` high on cycles 1..RST_CYCLES after the `start` edge. The first `core_en`=1 cycle is RST_CYCLES+1.
- Halt detection is zero-latency: `core_en` drops in the same cycle `stop_now` is true.
- `state`=HALT and `done`=1 follow on the next edge.
- `halt_cause` and `bp_hit` update on the same edge as the HALT entry.
- With `limit`=L and no other stop, exactly L enabled cycles occur and `cycles`=L at halt.

## Structure
- Package `mips_run_ctrl_pkg`: state encoding constants and halt-cause codes, shared with debug software headers and the bench.
- Sub-module `mips_bp_match` (params PC_W, N_BP): combinational comparator array producing the `bp_hit` vector and an any-hit flag.
- RESET hold counter: width `$clog2(RST_CYCLES+1)`.

## Test plan
Bench stub core: PC resets to 0 on `core_rst` and adds 4 on each `core_en`. Parameters RST_CYCLES=1, CYC_W=16 unless stated.

- Breakpoint: `bp_addr[0]`=0x30, `bp_en`=01, limit 0, start → `core_rst` high 1 cycle, 12 enabled cycles, then HALT with `pc_current`=0x30, `cycles`=12, `halt_cause`=1, `bp_hit`=01, `done` high exactly 1 cycle.
- Limit: no breakpoints, limit 50 → HALT with `cycles`=50, `pc_current`=0xC8, `halt_cause`=2.
- Single-step: `single_step`=1, 3 `step` pulses → `state`=PAUSE, `cycles`=3, PC=0x0C. Then `resume` with bp at 0x20 → HALT with `cycles`=8.
- Abort: `abort` at the 5th RUN cycle → `core_en` low that cycle, `cycles`=4, `halt_cause`=3. Also: `start` during RUN has no effect.
- Simultaneous stop: bp0=bp1=0x10 with limit 4 → both true at PC 0x10; `halt_cause`=1, `bp_hit`=11, `cycles`=4.
- Reset and restart: `rst` mid-RUN → IDLE with all registered outputs at reset values; a new `start` restarts cleanly from PC 0. `start` from HALT re-runs with `cycles` cleared.

Source files
------------

// File: rtl/mips_run_ctrl_pkg.sv
// Shared encodings for the MIPS run-control block: FSM state codes and halt causes.
// The numeric values are visible to debug software through the state/halt_cause outputs.
package mips_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_BP    = 2'd1,
    CAUSE_LIMIT = 2'd2,
    CAUSE_ABORT = 2'd3
  } halt_cause_t;

  // Priority: abort > breakpoint > limit; the limit is the only remaining stop source.
  function automatic halt_cause_t pick_cause(input logic abort, input logic bp_any);
    if (abort)       return CAUSE_ABORT;
    else if (bp_any) return CAUSE_BP;
    else             return CAUSE_LIMIT;
  endfunction

endpackage

// File: rtl/mips_bp_match.sv
// Combinational breakpoint comparator array: one enabled equality compare per entry.
module mips_bp_match #(
  parameter int PC_W = 32,
  parameter int N_BP = 2
) (
  input  logic [N_BP*PC_W-1:0] bp_addr,
  input  logic [N_BP-1:0]      bp_en,
  input  logic [PC_W-1:0]      pc,
  output logic [N_BP-1:0]      hit,
  output logic                 any_hit
);

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_BP; i++) begin
      hit[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc);
    end
  end

  assign any_hit = |hit;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run control for a MIPS core: reset sequencing, free-run / single-step execution,
// breakpoint and cycle-budget halting, with halt cause reporting.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int N_BP       = 2,
  parameter int CYC_W      = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 single_step,
  input  logic                 step,
  input  logic                 resume,
  input  logic                 abort,
  input  logic [CYC_W-1:0]     cycle_limit,
  input  logic [N_BP*PC_W-1:0] bp_addr,
  input  logic [N_BP-1:0]      bp_en,
  input  logic [PC_W-1:0]      pc_current,
  output logic                 core_rst,
  output logic                 core_en,
  output logic [2:0]           state,
  output logic [CYC_W-1:0]     cycles,
  output logic [1:0]           halt_cause,
  output logic [N_BP-1:0]      bp_hit,
  output logic                 done
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  run_state_t        state_q, state_d;
  halt_cause_t       cause_q;
  logic              ss_q;
  logic [CYC_W-1:0]  limit_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [RC_W-1:0]   rc_q;
  logic [N_BP-1:0]   hit_q;
  logic              done_q;

  logic [N_BP-1:0]   hit_now;
  logic              bp_any;
  logic              lim_hit;
  logic              stop_now;
  logic              accept_start;
  logic              halt_entry;

  mips_bp_match #(
    .PC_W (PC_W),
    .N_BP (N_BP)
  ) u_bp_match (
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .pc      (pc_current),
    .hit     (hit_now),
    .any_hit (bp_any)
  );

  assign lim_hit      = (limit_q != '0) && (cyc_q == limit_q);
  assign stop_now     = abort | bp_any | lim_hit;
  assign accept_start = start && (state_q == ST_IDLE || state_q == ST_HALT);
  assign halt_entry   = (state_d == ST_HALT) && (state_q != ST_HALT);

  always_comb begin
    state_d = state_q;
    core_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: if (start) state_d = ST_RESET;
      ST_RESET: begin
        if (abort)               state_d = ST_HALT;
        else if (rc_q == RC_LAST) state_d = ss_q ? ST_PAUSE : ST_RUN;
      end
      ST_RUN: begin
        core_en = ~stop_now;
        if (stop_now) state_d = ST_HALT;
      end
      ST_PAUSE: begin
        core_en = step & ~stop_now;
        // step wins over resume: the stepped cycle happens here, RUN starts next cycle
        if (abort)                 state_d = ST_HALT;
        else if (step && stop_now) state_d = ST_HALT;
        else if (resume)           state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) core_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      ss_q    <= 1'b0;
      limit_q <= '0;
      cyc_q   <= '0;
      rc_q    <= '0;
      hit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= halt_entry;
      if (state_q == ST_RESET) rc_q <= rc_q + 1'b1;
      else                     rc_q <= '0;
      if (accept_start) begin
        cyc_q   <= '0;
        cause_q <= CAUSE_NONE;
        hit_q   <= '0;
        ss_q    <= single_step;
        limit_q <= cycle_limit;
      end else if (core_en && cyc_q != '1) begin
        cyc_q <= cyc_q + 1'b1;
      end
      if (halt_entry) begin
        cause_q <= pick_cause(abort, bp_any);
        hit_q   <= hit_now;
      end
    end
  end

  assign core_rst   = rst | (state_q == ST_RESET);
  assign state      = state_q;
  assign cycles     = cyc_q;
  assign halt_cause = cause_q;
  assign bp_hit     = hit_q;
  assign done       = done_q;

endmodule
